ingress_pacer: RTL
==================

// Module: ingress_pacer
// PURPOSE
//  Upstream feeder for the nibble-split off-chip transfer stage. That stage consumes
//  data_in/valid_in with no backpressure and needs >=5 cycles per byte.
//  This block buffers bytes from a valid/ready source in a FIFO. It emits them as
//  single-cycle tx_valid pulses spaced >=GAP cycles apart. In-flight bytes are capped
//  by credits returned when the transfer stage's output handshake completes.
// PARAMETERS
//  DEPTH         8  FIFO entries; power of 2, >=2
//  GAP           5  min clock edges between consecutive tx_valid pulses; >=1
//  MAX_INFLIGHT  4  max bytes issued but not yet credited back; >=1
// PORTS
//  clk          in   1   clock; all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  src_data     in   8   source byte
//  src_valid    in   1   source byte valid
//  src_ready    out  1   FIFO can accept; = !full, forced 0 while rst high
//  tx_data      out  8   byte to transfer stage data_in; registered
//  tx_valid     out  1   one-cycle pulse to transfer stage valid_in; registered
//  credit_ret   in   1   one pulse per byte delivered downstream (its valid_out & ready)
//  fifo_level   out  $clog2(DEPTH)+1  current FIFO occupancy
//  inflight     out  $clog2(MAX_INFLIGHT)+1  issued-minus-credited count
//  pacer_state  out  2   0 IDLE, 1 GAP, 2 BLOCK, 3 ISSUE (debug)
//  err          out  1   sticky: credit_ret seen while inflight==0
// BEHAVIOUR
//  Reset (sync, any time incl. mid-operation)
//   - FIFO flushed: ptrs=0, level=0.
//   - tx_valid=0, tx_data=0, inflight=0, gap_cnt=0, err=0, pacer_state=IDLE.
//   - A tx_valid pulse in progress is dropped.
//  Push
//   - src_valid & src_ready at edge E: byte written, level+1.
//   - No write when full; src_data is don't-care when src_valid=0.
//  Issue
//   - Eligible = level!=0 & gap_cnt==0 & inflight<MAX_INFLIGHT, from registered state only.
//   - At edge I with eligible: tx_valid<=1, tx_data<=FIFO head, pop, gap_cnt<=GAP-1, inflight+1.
//   - Otherwise tx_valid<=0; tx_data holds its last value.
//   - gap_cnt decrements each edge while nonzero, so the next issue is no earlier than I+GAP.
//   - No bypass: byte accepted at edge E issues no earlier than edge E+1.
//  Push+pop at same edge: both happen, level unchanged; full stays full only if no pop.
//  Credits
//   - credit_ret at edge C: inflight-1, effective for eligibility from edge C+1.
//   - Issue and credit_ret at same edge: inflight unchanged.
//   - credit_ret with inflight==0 and no issue: inflight stays 0, err<=1.
//  pacer_state (next-state, registered)
//   - ISSUE if issuing this edge.
//   - else IDLE if level==0 (after push/pop).
//   - else GAP if gap_cnt!=0.
//   - else BLOCK (credit-limited).
//  Ordering: strict FIFO; no byte dropped or duplicated; pointers wrap mod DEPTH.
// TESTING
//  T1 reset
//   - rst high 3 cycles with src_valid=1 -> src_ready=0, tx_valid=0, level=0, err=0.
//   - After release: src_ready=1.
//  T2 spacing (credits returned promptly)
//   - Push 0x05,0xA3,0x3C at edges 1,2,3.
//   - -> tx_valid at edges 2,7,12 with data 0x05,0xA3,0x3C; no other pulses.
//  T3 credit cap (credit_ret held 0)
//   - Push 6 bytes -> exactly 4 issued at edges 2,7,12,17; inflight=4; state=BLOCK.
//   - credit_ret pulse at edge 30 -> 5th byte issued at edge 31.
//  T4 full
//   - No credits, push 12 bytes -> 4 issued; level reaches 8; src_ready=0.
//   - Further src_valid bytes are not written; order preserved after credits return.
//  T5 error
//   - credit_ret at idle with inflight=0 -> err=1 next edge, stays 1, inflight=0.
//   - rst clears err.
//  T6 simultaneous and mid-operation
//   - Issue edge coincides with credit_ret -> inflight unchanged.
//   - Reset asserted while level=5, inflight=3 -> all cleared next edge.
//   - No tx_valid for flushed bytes.

Source files
------------

// File: rtl/ingress_pacer.sv
// ============================================================================
//  Module  : ingress_pacer
//  Purpose : Buffers source bytes and issues them as paced, credit-limited
//            single-cycle pulses to the nibble-split transfer stage.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ingress_pacer #(
  parameter int DEPTH        = 8,
  parameter int GAP          = 5,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [7:0]                      src_data,
  input  logic                            src_valid,
  output logic                            src_ready,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  input  logic                            credit_ret,
  output logic [$clog2(DEPTH):0]          fifo_level,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic [1:0]                      pacer_state,
  output logic                            err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  localparam int GW = $clog2(GAP) + 1;

  localparam logic [LW-1:0] C_DEPTH      = LW'(DEPTH);
  localparam logic [IW-1:0] C_MAX_INFL   = IW'(MAX_INFLIGHT);
  localparam logic [GW-1:0] C_GAP_RELOAD = GW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_BLOCK = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          err_q, err_d;
  logic          tx_valid_q;
  logic [7:0]    tx_data_q;
  state_t        state_q, state_d;

  logic w_full, w_push, w_issue;

  assign w_full    = (level_q == C_DEPTH);
  assign src_ready = !w_full && !rst;
  assign w_push    = src_valid && src_ready;
  // Eligibility looks only at registered state, so a byte pushed at an edge cannot issue at that same edge.
  assign w_issue   = (level_q != '0) && (gap_q == '0) && (inflight_q < C_MAX_INFL);

  always_comb begin
    level_d    = level_q;
    gap_d      = gap_q;
    inflight_d = inflight_q;
    err_d      = err_q;
    state_d    = S_IDLE;

    case ({w_push, w_issue})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (w_issue)
      gap_d = C_GAP_RELOAD;
    else if (gap_q != '0)
      gap_d = gap_q - GW'(1);

    if (w_issue && !credit_ret) begin
      inflight_d = inflight_q + IW'(1);
    end else if (!w_issue && credit_ret) begin
      if (inflight_q == '0)
        err_d = 1'b1;
      else
        inflight_d = inflight_q - IW'(1);
    end

    if (w_issue)
      state_d = S_ISSUE;
    else if (level_d == '0)
      state_d = S_IDLE;
    else if (gap_d != '0)
      state_d = S_GAP;
    else
      state_d = S_BLOCK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      gap_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      state_q    <= S_IDLE;
    end else begin
      level_q    <= level_d;
      gap_q      <= gap_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      state_q    <= state_d;
      tx_valid_q <= w_issue;
      if (w_push)
        wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_issue) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        tx_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage needs no reset; w_push is already low while rst is high.
  always_ff @(posedge clk) begin
    if (w_push)
      mem_q[wr_ptr_q] <= src_data;
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign fifo_level  = level_q;
  assign inflight    = inflight_q;
  assign pacer_state = state_q;
  assign err         = err_q;

endmodule

`default_nettype wire
